// File: rtl/atan2_pkg.sv
// atan2_pkg: constants shared by the atan2 CORDIC block.
//   - S_IDLE/S_PREROT/S_ITER/S_DONE : controller state encodings
//   - ATAN_LUT                      : atan(2^-i) as a 32-bit binary angle
//                                     (2^32 = full circle), i = 0..31
//   - atan_lut_scaled()             : rounds an ATAN_LUT entry to a WIDTH-bit
//                                     binary angle (WIDTH up to 32)
//   - GAIN_K / GAIN_FRAC            : CORDIC gain compensation 0.607253 as an
//                                     unsigned fixed-point constant
package atan2_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PREROT = 2'd1;
  localparam logic [1:0] S_ITER   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [31:0] ATAN_LUT [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // 0.607253 * 2^16, rounded
  localparam int              GAIN_FRAC = 16;
  localparam logic [15:0]     GAIN_K    = 16'd39797;

  // Round-to-nearest rescale of a 32-bit table entry down to 'width' bits.
  function automatic logic [31:0] atan_lut_scaled(input int idx, input int width);
    logic [32:0] t;
    logic [4:0]  sel;
    sel = idx[4:0];
    if (width >= 32) begin
      return ATAN_LUT[sel];
    end
    t = {1'b0, ATAN_LUT[sel]} + (33'd1 << (31 - width));
    return 32'(t >> (32 - width));
  endfunction

endpackage

// File: rtl/atan2_cordic_if.sv
// atan2_cordic_if: request/result bundle for the atan2 CORDIC block.
//   start, sine, cos          : request side (driven by the master)
//   ready, valid, busy, angle : status/result side (driven by the slave)
//   magnitude                 : only present when ATAN2_MAGNITUDE_EN is defined
// Optional feature macro: ATAN2_MAGNITUDE_EN.
interface atan2_cordic_if #(
  parameter int WIDTH = 16
);
  logic                    start;
  logic signed [WIDTH-1:0] sine;
  logic signed [WIDTH-1:0] cos;
  logic                    ready;
  logic                    valid;
  logic                    busy;
  logic        [WIDTH-1:0] angle;
`ifdef ATAN2_MAGNITUDE_EN
  logic        [WIDTH-1:0] magnitude;
`endif

  modport master (
    output start, sine, cos,
`ifdef ATAN2_MAGNITUDE_EN
    input  magnitude,
`endif
    input  ready, valid, busy, angle
  );

  modport slave (
    input  start, sine, cos,
`ifdef ATAN2_MAGNITUDE_EN
    output magnitude,
`endif
    output ready, valid, busy, angle
  );
endinterface

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring-mode CORDIC micro-rotation.
//   x_in, y_in : signed vector components (XW bits)
//   z_in       : accumulated binary angle (ZW bits, wraps mod 2^ZW)
//   shift      : iteration index i, used as the arithmetic shift amount
//   lut        : atan(2^-i) in binary-angle LSBs
//   x_out, y_out, z_out : rotated vector and updated angle
// The rotation direction drives y towards zero; both updates use the
// incoming x/y so the pair behaves as a simultaneous update.
module cordic_vec_stage #(
  parameter int XW = 18,
  parameter int ZW = 16,
  parameter int SW = 4
) (
  input  logic signed [XW-1:0] x_in,
  input  logic signed [XW-1:0] y_in,
  input  logic        [ZW-1:0] z_in,
  input  logic        [SW-1:0] shift,
  input  logic        [ZW-1:0] lut,
  output logic signed [XW-1:0] x_out,
  output logic signed [XW-1:0] y_out,
  output logic        [ZW-1:0] z_out
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x_in >>> shift;
  assign y_sh = y_in >>> shift;

  always_comb begin
    x_out = x_in;
    y_out = y_in;
    z_out = z_in;
    if (!y_in[XW-1]) begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + lut;
    end else begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - lut;
    end
  end

endmodule

// File: rtl/atan2_cordic.sv
// atan2_cordic: iterative vectoring CORDIC, (sine, cos) -> binary angle.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   en    : clock enable; all state holds while low
//   bus   : atan2_cordic_if.slave (start/sine/cos in, ready/valid/busy/angle out,
//           plus magnitude when ATAN2_MAGNITUDE_EN is defined)
// Sequence: IDLE -> PREROT -> ITER (ITERATIONS cycles) -> DONE -> IDLE.
// valid pulses ITERATIONS+2 enabled clocks after the accepting edge.
// Optional feature macro: ATAN2_MAGNITUDE_EN (gain-compensated |(x,y)|).
module atan2_cordic
  import atan2_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  atan2_cordic_if.slave bus
);

  // Two guard bits: room for negating -2^(WIDTH-1) and for the CORDIC gain.
  localparam int             XW        = WIDTH + 2;
  localparam int             CW        = $clog2(ITERATIONS);
  localparam logic [CW-1:0]  LAST_ITER = CW'(ITERATIONS - 1);

  logic [1:0]           state_reg;
  logic signed [XW-1:0] x_reg;
  logic signed [XW-1:0] y_reg;
  logic [WIDTH-1:0]     z_reg;
  logic [CW-1:0]        iter_reg;
  logic                 zero_reg;
  logic [WIDTH-1:0]     angle_reg;
  logic                 valid_reg;

  logic signed [XW-1:0] x_next;
  logic signed [XW-1:0] y_next;
  logic [WIDTH-1:0]     z_next;
  logic [WIDTH-1:0]     lut_val;
  logic [WIDTH-1:0]     lut_rom [ITERATIONS];

  for (genvar gi = 0; gi < ITERATIONS; gi++) begin : g_lut
    localparam logic [31:0] LUT_ENTRY = atan_lut_scaled(gi, WIDTH);
    assign lut_rom[gi] = LUT_ENTRY[WIDTH-1:0];
  end

  assign lut_val = lut_rom[iter_reg];

  cordic_vec_stage #(
    .XW (XW),
    .ZW (WIDTH),
    .SW (CW)
  ) u_stage (
    .x_in  (x_reg),
    .y_in  (y_reg),
    .z_in  (z_reg),
    .shift (iter_reg),
    .lut   (lut_val),
    .x_out (x_next),
    .y_out (y_next),
    .z_out (z_next)
  );

`ifdef ATAN2_MAGNITUDE_EN
  // x * GAIN_K / 2^GAIN_FRAC as a chain of shifted partial sums, rounded.
  localparam int PW = XW + GAIN_FRAC;

  logic [PW-1:0]    gain_x;
  logic [PW-1:0]    gain_acc [GAIN_FRAC+1];
  logic [XW-1:0]    mag_int;
  logic [WIDTH-1:0] mag_sat;
  logic [WIDTH-1:0] mag_reg;

  assign gain_x      = x_reg[XW-1] ? '0 : {{GAIN_FRAC{1'b0}}, x_reg};
  assign gain_acc[0] = PW'(1) << (GAIN_FRAC - 1);

  for (genvar gi = 0; gi < GAIN_FRAC; gi++) begin : g_gain
    assign gain_acc[gi+1] = gain_acc[gi] + (GAIN_K[gi] ? (gain_x << gi) : '0);
  end

  assign mag_int = XW'(gain_acc[GAIN_FRAC] >> GAIN_FRAC);
  assign mag_sat = (mag_int[XW-1:WIDTH] != '0) ? '1 : mag_int[WIDTH-1:0];
  assign bus.magnitude = mag_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      iter_reg  <= '0;
      zero_reg  <= 1'b0;
      angle_reg <= '0;
      valid_reg <= 1'b0;
`ifdef ATAN2_MAGNITUDE_EN
      mag_reg   <= '0;
`endif
    end else if (en) begin
      valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            x_reg     <= {{2{bus.cos[WIDTH-1]}}, bus.cos};
            y_reg     <= {{2{bus.sine[WIDTH-1]}}, bus.sine};
            // The vectoring loop would otherwise accumulate every LUT entry.
            zero_reg  <= (bus.sine == '0) && (bus.cos == '0);
            state_reg <= S_PREROT;
          end
        end
        S_PREROT: begin
          // Fold the left half-plane onto the right by a 180-degree rotation.
          if (x_reg[XW-1]) begin
            x_reg <= -x_reg;
            y_reg <= -y_reg;
            z_reg <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            z_reg <= '0;
          end
          iter_reg  <= '0;
          state_reg <= S_ITER;
        end
        S_ITER: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          if (iter_reg == LAST_ITER) begin
            state_reg <= S_DONE;
          end else begin
            iter_reg <= iter_reg + 1'b1;
          end
        end
        default: begin
          angle_reg <= zero_reg ? '0 : z_reg;
          valid_reg <= 1'b1;
`ifdef ATAN2_MAGNITUDE_EN
          mag_reg   <= mag_sat;
`endif
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state_reg == S_IDLE);
  assign bus.busy  = (state_reg == S_PREROT) || (state_reg == S_ITER);
  assign bus.valid = valid_reg;
  assign bus.angle = angle_reg;

endmodule

// File: doc/atan2_cordic.md
Name: atan2_cordic

Overview:
Recovers phase from a sine/cos sample pair. It is the inverse of the sine_cos generator: the generator turns phase into (sine, cos), and this block turns (sine, cos) back into a binary angle.
Implementation is an iterative CORDIC in vectoring mode, one micro-rotation per clock, with a start/ready/valid handshake. It sits downstream of sine_cos, or any I/Q source, in closed-loop phase checks alongside the comparator.

Parameters:
WIDTH, 16, sample and angle width; sine/cos are signed two's complement, angle is unsigned binary angle (2^WIDTH = full circle).
ITERATIONS, 14, number of CORDIC micro-rotations; legal range 4..WIDTH-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
en  input  1  clock enable; when low, all state (FSM, datapath, outputs) holds
start  input  1  request; sampled only when ready=1 and en=1
sine  input  WIDTH  signed y component, captured on accepted start
cos  input  WIDTH  signed x component, captured on accepted start
ready  output  1  high in IDLE only
valid  output  1  one-cycle pulse when angle is updated
angle  output  WIDTH  unsigned binary angle, atan2(sine, cos) mod 2^WIDTH
busy  output  1  high in PREROT and ITER

Behaviour:
- Reset (reset=0, asynchronous): FSM returns to IDLE; ready=1; valid=0; busy=0; angle=0; internal x/y/z/iteration counter=0. Reset mid-operation aborts the operation and produces no valid.
- States: IDLE -> PREROT -> ITER -> DONE -> IDLE. All transitions are gated by en.
- IDLE: on start=1, latch sine/cos sign-extended to WIDTH+2 bits, then go to PREROT.
- PREROT (1 cycle), quadrant fold:
  - if cos<0: x=-cos, y=-sine, z=2^(WIDTH-1) (180°);
  - else: x=cos, y=sine, z=0.
  - The extended width makes negating -2^(WIDTH-1) exact.
- ITER (ITERATIONS cycles, counter i=0..ITERATIONS-1):
  - if y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN_LUT[i];
  - else: x-=y>>>i, y+=x>>>i, z-=ATAN_LUT[i].
  - Shifts are arithmetic. Each update uses the previous-cycle x/y.
- DONE (1 cycle): angle<=z[WIDTH-1:0], which wraps mod 2^WIDTH, so negative z maps into 2^WIDTH-|z|. valid=1 this cycle only; then return to IDLE.
- Latency: valid pulses exactly ITERATIONS+2 enabled clocks after the accepting edge. Throughput is one result per ITERATIONS+3 enabled clocks.
- angle holds its value between valid pulses.
- start while ready=0 is ignored (not queued). start held high continuously restarts on each IDLE cycle.
- sine=0, cos=0: angle=0.
- Accuracy: |error| <= 2 LSB at default parameters for input magnitude >= 2^(WIDTH-4).
- en=0 mid-operation freezes the state. Resuming continues the operation and gives the identical result; the latency counts enabled clocks only.

Optional Feature:
Macro ATAN2_MAGNITUDE_EN.
- Defined:
  - adds output port magnitude (WIDTH bits, unsigned) = final x * 0.607253 (CORDIC gain compensation), computed by a constant shift-add in DONE, saturated to 2^WIDTH-1;
  - magnitude is valid with the valid pulse; latency is unchanged; resets to 0.
- Undefined: no magnitude port or logic; x still iterates internally.

Decomposition:
- Shared package atan2_pkg holds:
  - ATAN_LUT constant array (atan(2^-i) in binary-angle LSBs, for WIDTH up to 32, scaled by WIDTH);
  - state enumeration localparams (S_IDLE, S_PREROT, S_ITER, S_DONE);
  - CORDIC gain-compensation constant.
- One sub-module is natural: cordic_vec_stage. It is the combinational single micro-rotation (x, y, z, shift i, lut value -> x', y', z') and is instantiated once and reused every cycle.

Test Plan:
- sine=0, cos=16384, start 1 cycle -> valid exactly 16 clocks later, angle=0 ±2.
- sine=16384, cos=0 -> angle=16384 ±2; sine=-16384, cos=0 -> angle=49152 ±2.
- Quadrant/sign edges:
  - sine=0, cos=-16384 -> angle=32768 ±2;
  - sine=-32768, cos=-32768 -> angle=40960 ±2, no overflow;
  - sine=cos=0 -> angle=0.
- start pulsed again at cycle 5 of an operation -> ignored, single valid, ready low until after DONE. en dropped for 7 cycles mid-ITER -> same angle, valid 7 cycles later.
- reset asserted at ITER cycle 6 -> immediate ready=1, busy=0, angle=0, no valid. A new request then completes normally.
- Closed loop with sine_cos (WIDTH=16), one sample per result, 2000 samples -> successive angles strictly monotonic mod 2^16. With ATAN2_MAGNITUDE_EN, magnitude stays within ±4 LSB of the generator amplitude.
